// File: rtl/register_file_sb.sv
// register_file_sb: decode-stage register file with scoreboard.
//
// Purpose
//   Parametrised register file that resets each register to its own index.
//   It has two registered read ports with write-through bypass from the
//   write-back port. A per-register pending bit tracks outstanding producers,
//   and a combinational Stall flag reports read-after-write hazards.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width; NREGS = 2**ADDR_W registers
//   ZERO_R0  1 = R0 reads as zero, ignores writes and is never marked pending
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   Rs, Rd       read addresses for port 1 and port 2
//   Rs_En, Rd_En operand-used flags; they only gate the hazard check
//   Write_Reg    write-back destination
//   Write_Data   write-back data
//   Reg_Write    write-back enable
//   Issue_Valid  an instruction with a destination is issuing
//   Issue_Reg    destination of that instruction; it is marked pending
//   Data1, Data2 registered read data
//   Stall        combinational RAW hazard flag
//   Busy_Vec     registered pending bits; bit k is register k
module register_file_sb #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0,
  localparam int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rd,
  input  logic              Rs_En,
  input  logic              Rd_En,
  input  logic [ADDR_W-1:0] Write_Reg,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Reg_Write,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Reg,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic              Stall,
  output logic [NREGS-1:0]  Busy_Vec
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] data1_q, data2_q;
  logic [DATA_W-1:0] rd1_s, rd2_s;
  logic              hit1_s, hit2_s;
  logic              stall_s;
  logic              wr_allow_s, iss_allow_s;

  // Read values with write-through bypass and the optional hardwired-zero R0.
  always_comb begin
    hit1_s = Reg_Write && (Write_Reg == Rs);
    hit2_s = Reg_Write && (Write_Reg == Rd);
    rd1_s  = regs_q[Rs];
    rd2_s  = regs_q[Rd];
    if ((ZERO_R0 != 0) && (Rs == '0)) begin
      rd1_s = '0;
    end else if (hit1_s) begin
      rd1_s = Write_Data;
    end else begin
      rd1_s = regs_q[Rs];
    end
    if ((ZERO_R0 != 0) && (Rd == '0)) begin
      rd2_s = '0;
    end else if (hit2_s) begin
      rd2_s = Write_Data;
    end else begin
      rd2_s = regs_q[Rd];
    end
  end

  // RAW hazard: a pending source stalls unless write-back delivers it this cycle.
  always_comb begin
    stall_s = reset &&
              ((Rs_En && busy_q[Rs] && !hit1_s) ||
               (Rd_En && busy_q[Rd] && !hit2_s));
  end

  // Next-state for the register array and the scoreboard.
  always_comb begin
    wr_allow_s  = Reg_Write && !((ZERO_R0 != 0) && (Write_Reg == '0));
    iss_allow_s = Issue_Valid && !stall_s && !((ZERO_R0 != 0) && (Issue_Reg == '0));
    regs_d      = regs_q;
    busy_d      = busy_q;
    if (wr_allow_s) begin
      regs_d[Write_Reg] = Write_Data;
    end else begin
      regs_d[Write_Reg] = regs_q[Write_Reg];
    end
    // The clear is applied before the set, so a new producer issuing to the
    // register being written back keeps it pending.
    if (Reg_Write) begin
      busy_d[Write_Reg] = 1'b0;
    end else begin
      busy_d[Write_Reg] = busy_q[Write_Reg];
    end
    if (iss_allow_s) begin
      busy_d[Issue_Reg] = 1'b1;
    end else begin
      busy_d[Issue_Reg] = busy_d[Issue_Reg];
    end
  end

  // State registers; reset loads each register with its own index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NREGS; k++) begin
        if ((ZERO_R0 != 0) && (k == 0)) begin
          regs_q[k] <= '0;
        end else begin
          regs_q[k] <= DATA_W'(k);
        end
      end
      busy_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      data1_q <= rd1_s;
      data2_q <= rd2_s;
    end
  end

  assign Data1    = data1_q;
  assign Data2    = data2_q;
  assign Busy_Vec = busy_q;
  assign Stall    = stall_s;

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 8x8 register file in the pipelined core.
- Adds configurable data width, register count and an R0-hardwired-zero option.
- Has a clocked write port with reset to index values, registered reads with write-through bypass, and a per-register pending (scoreboard) bit.
- Sits in the decode stage: reads operands, raises Stall on RAW hazards, and is written by write-back.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; NREGS = 2**ADDR_W registers.
- ZERO_R0, 0: 1 = R0 reads 0, ignores writes and is never marked pending.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- Rs  input  ADDR_W  read address, port 1.
- Rd  input  ADDR_W  read address, port 2.
- Rs_En  input  1  port-1 operand is used; enables hazard check.
- Rd_En  input  1  port-2 operand is used; enables hazard check.
- Write_Reg  input  ADDR_W  write-back destination.
- Write_Data  input  DATA_W  write-back data.
- Reg_Write  input  1  write-back enable.
- Issue_Valid  input  1  decode issues an instruction with a destination.
- Issue_Reg  input  ADDR_W  destination of the issuing instruction; marked pending.
- Data1  output  DATA_W  registered read data, port 1.
- Data2  output  DATA_W  registered read data, port 2.
- Stall  output  1  combinational RAW hazard flag.
- Busy_Vec  output  NREGS  registered pending bits, bit k = register k.

Behaviour:
- Reset: sampled at a rising edge with reset==0. At that edge:
  - Register[k] <= k, truncated to DATA_W; Register[0] <= 0 when ZERO_R0=1.
  - Busy_Vec <= 0, Data1 <= 0, Data2 <= 0.
  - Stall is forced to 0 while reset==0.
  - All writes, issues and reads are ignored during reset.
  - Reset asserted mid-operation discards pending bits and in-flight writes on that edge.
- Write: at a rising edge with reset==1 and Reg_Write==1, Register[Write_Reg] <= Write_Data.
  - Suppressed when ZERO_R0=1 and Write_Reg==0.
- Read latency: 1 cycle. At each edge, Data1 <= value(Rs) and Data2 <= value(Rd), where value(a) is:
  - 0 if ZERO_R0=1 and a==0; else
  - Write_Data if Reg_Write==1 and Write_Reg==a (write-through bypass, same edge); else
  - Register[a].
- Both ports may address the same register; both may bypass simultaneously.
- Reads are unconditional; Rs_En/Rd_En affect only Stall.
- Hazard (combinational, reset==1):
  - hz(a, en) = en && Busy_Vec[a] && !(Reg_Write && Write_Reg==a).
  - Stall = hz(Rs, Rs_En) | hz(Rd, Rd_En).
  - A write-back in the current cycle clears the hazard for that register in the same cycle; the bypass supplies the data.
- Scoreboard update at each edge (reset==1):
  - Clear: if Reg_Write, Busy_Vec[Write_Reg] <= 0.
  - Set: if Issue_Valid && !Stall, Busy_Vec[Issue_Reg] <= 1.
  - Set has priority over clear when Issue_Reg==Write_Reg in the same cycle (the new producer owns the register).
  - Issue_Valid while Stall==1 is ignored, so the stalled instruction re-issues.
  - With ZERO_R0=1, Issue_Reg==0 sets nothing and Busy_Vec[0] stays 0.
- Write-back to a non-pending register is legal: data is written and Busy_Vec is unchanged.
- Register index wrap: none. Every ADDR_W value is a valid register; no out-of-range condition exists.

Test Plan:
1. Reset and read: reset=0 for 1 edge, then reset=1, Rs=5, Rd=7 -> after the next edge Data1=5, Data2=7, Busy_Vec=0, Stall=0.
2. Write and bypass: Reg_Write=1, Write_Reg=3, Write_Data=8'hA5, Rs=3, Rd=3 in the same cycle -> after the edge Data1=Data2=8'hA5. The next cycle, with Reg_Write=0, still reads 8'hA5.
3. RAW stall: Issue_Valid=1, Issue_Reg=4 -> Busy_Vec=8'h10.
   - Next cycle Rs=4, Rs_En=1, Issue_Valid=1, Issue_Reg=6 -> Stall=1 and Busy_Vec stays 8'h10.
   - Write-back Reg 4 = 8'h3C -> Stall=0 that cycle, Data1=8'h3C next cycle, Busy_Vec[4]=0.
4. Simultaneous set/clear: Busy_Vec[2]=1; Reg_Write=1, Write_Reg=2, Issue_Valid=1, Issue_Reg=2, no stall -> Register[2] updated, Busy_Vec[2] remains 1.
5. ZERO_R0=1 variant: write 8'hFF to R0, issue R0 -> Rs=0 reads 0, Busy_Vec[0]=0, Stall=0 with Rs_En=1.
6. Reset mid-operation: Busy_Vec=8'h0C, R1 written with 8'h77; assert reset=0 for one edge -> Busy_Vec=0, R1 reads 1, Data1/Data2=0 at that edge, Stall=0.
